// File: rtl/video_timing_gen_if.sv
// Config handshake bundle for video_timing_gen.
// Master offers a timing set; slave accepts it or flags it illegal.
interface video_timing_gen_if #(
  parameter int YW = 9
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [7:0]    cfg_h_total;
  logic [7:0]    cfg_h_active;
  logic [7:0]    cfg_h_start;
  logic [7:0]    cfg_h_sync;
  logic [YW-1:0] cfg_v_total;
  logic [YW-1:0] cfg_v_active;
  logic [YW-1:0] cfg_v_start;
  logic [YW-1:0] cfg_v_sync;
  logic          cfg_interlace;
  logic          cfg_err;

  modport master (
    output cfg_valid,
    output cfg_h_total, cfg_h_active,
    output cfg_h_start, cfg_h_sync,
    output cfg_v_total, cfg_v_active,
    output cfg_v_start, cfg_v_sync,
    output cfg_interlace,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_h_total, cfg_h_active,
    input  cfg_h_start, cfg_h_sync,
    input  cfg_v_total, cfg_v_active,
    input  cfg_v_start, cfg_v_sync,
    input  cfg_interlace,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/video_timing_gen.sv
// Programmable raster timing generator with field-boundary config shadowing.
// Optional line-compare interrupt enabled by defining VT_LINE_IRQ_EN.
module video_timing_gen #(
  parameter int XW   = 13,
  parameter int YW   = 9,
  parameter int UNIT = 16
) (
  input  logic          clk,
  input  logic          reset,
  video_timing_gen_if.slave cfg,
  input  logic [YW-1:0] line_cmp,
  output logic          irq_line,
  output logic [XW-1:0] video_x,
  output logic [YW-1:0] video_y,
  output logic          hsync,
  output logic          vsync,
  output logic          hblank,
  output logic          vblank,
  output logic          new_line,
  output logic          new_frame,
  output logic          parity,
  output logic          fake_parity
);

  typedef struct packed {
    logic [7:0]    ht;
    logic [7:0]    ha;
    logic [7:0]    hs;
    logic [7:0]    hsy;
    logic [YW-1:0] vt;
    logic [YW-1:0] va;
    logic [YW-1:0] vs;
    logic [YW-1:0] vsy;
    logic          il;
  } tcfg_t;

  localparam logic [XW-1:0] UW = XW'(UNIT);

  localparam tcfg_t A_RST = '{
    ht:  8'd120,
    ha:  8'd96,
    hs:  8'd20,
    hsy: 8'd9,
    vt:  YW'(312),
    va:  YW'(280),
    vs:  YW'(26),
    vsy: YW'(3),
    il:  1'b0
  };

  tcfg_t         a_q, a_d, p_q, p_d, p_in;
  logic          pv_q, pv_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          par_q, par_d;
  logic          fpar_q, fpar_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          hb_q, hb_d;
  logic          vb_q, vb_d;
  logic          nl_q, nl_d;
  logic          nf_q, nf_d;
  logic          err_q, err_d;

  logic          wrap, fend, y_last;
  logic          xfer, legal;
  logic [8:0]    hsum;
  logic [YW:0]   vsum;
  logic [XW-1:0] xt_c, xt_n, hsw_n, half_n;
  logic [XW-1:0] hb_lo, hb_hi;
  logic [YW:0]   vsp, vep;

  always_comb begin
    p_in.ht  = cfg.cfg_h_total;
    p_in.ha  = cfg.cfg_h_active;
    p_in.hs  = cfg.cfg_h_start;
    p_in.hsy = cfg.cfg_h_sync;
    p_in.vt  = cfg.cfg_v_total;
    p_in.va  = cfg.cfg_v_active;
    p_in.vs  = cfg.cfg_v_start;
    p_in.vsy = cfg.cfg_v_sync;
    p_in.il  = cfg.cfg_interlace;

    hsum  = {1'b0, p_in.hs} + {1'b0, p_in.ha};
    vsum  = {1'b0, p_in.vs} + {1'b0, p_in.va};
    legal = (p_in.ht >= 8'd2)
         && (p_in.hsy < p_in.ht)
         && (hsum <= {1'b0, p_in.ht})
         && (p_in.vsy < p_in.vt)
         && (vsum <= {1'b0, p_in.vt});
    xfer  = cfg.cfg_valid && !pv_q;

    // Even fields carry the extra half-line, so they end one line later.
    xt_c   = XW'(a_q.ht) * UW;
    wrap   = (x_q == xt_c - XW'(1));
    y_last = par_q ? (y_q == a_q.vt - YW'(1))
                   : (y_q == a_q.vt);
    fend   = wrap && y_last;

    x_d    = wrap ? '0 : x_q + XW'(1);
    y_d    = fend ? '0
           : wrap ? y_q + YW'(1)
           : y_q;
    par_d  = fend ? (par_q ? !a_q.il : 1'b1) : par_q;
    fpar_d = fend ? !fpar_q : fpar_q;

    a_d  = (fend && pv_q) ? p_q : a_q;
    p_d  = p_q;
    pv_d = pv_q;
    if (xfer && legal) begin
      p_d  = p_in;
      pv_d = 1'b1;
    end else if (fend && pv_q) begin
      pv_d = 1'b0;
    end
    err_d = xfer && !legal;

    // Sync edges follow the config that owns the next position.
    xt_n   = XW'(a_d.ht) * UW;
    hsw_n  = XW'(a_d.hsy) * UW;
    half_n = xt_n >> 1;

    hs_d = hs_q;
    if (wrap)
      hs_d = 1'b1;
    if (x_d == hsw_n)
      hs_d = 1'b0;

    vs_d = vs_q;
    if (par_d) begin
      if (fend)
        vs_d = 1'b1;
      if (x_d == '0 && y_d == a_d.vsy)
        vs_d = 1'b0;
    end else begin
      if (x_d == half_n && y_d == '0)
        vs_d = 1'b1;
      if (x_d == half_n && y_d == a_d.vsy)
        vs_d = 1'b0;
    end

    hb_lo = XW'(a_q.hs) * UW;
    hb_hi = XW'({1'b0, a_q.hs} + {1'b0, a_q.ha}) * UW;
    hb_d  = !(x_q >= hb_lo && x_q < hb_hi);

    vsp  = {1'b0, a_q.vs} + {{YW{1'b0}}, !par_q};
    vep  = vsp + {1'b0, a_q.va};
    vb_d = !({1'b0, y_q} >= vsp && {1'b0, y_q} < vep);

    nl_d = wrap;
    nf_d = fend;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= A_RST;
      p_q    <= '0;
      pv_q   <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      par_q  <= 1'b1;
      fpar_q <= 1'b1;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      hb_q   <= 1'b1;
      vb_q   <= 1'b1;
      nl_q   <= 1'b0;
      nf_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      p_q    <= p_d;
      pv_q   <= pv_d;
      x_q    <= x_d;
      y_q    <= y_d;
      par_q  <= par_d;
      fpar_q <= fpar_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      hb_q   <= hb_d;
      vb_q   <= vb_d;
      nl_q   <= nl_d;
      nf_q   <= nf_d;
      err_q  <= err_d;
    end
  end

`ifdef VT_LINE_IRQ_EN
  logic irq_q, irq_d;

  always_comb irq_d = wrap && (y_d == line_cmp);

  always_ff @(posedge clk) begin
    if (reset)
      irq_q <= 1'b0;
    else
      irq_q <= irq_d;
  end

  assign irq_line = irq_q;
`else
  logic unused_cmp;
  assign unused_cmp = ^line_cmp;
  assign irq_line   = 1'b0;
`endif

  assign cfg.cfg_ready = !pv_q;
  assign cfg.cfg_err   = err_q;
  assign video_x       = x_q;
  assign video_y       = y_q;
  assign hsync         = hs_q;
  assign vsync         = vs_q;
  assign hblank        = hb_q;
  assign vblank        = vb_q;
  assign new_line      = nl_q;
  assign new_frame     = nf_q;
  assign parity        = par_q;
  assign fake_parity   = fpar_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized bench for video_timing_gen against a raster-position model.
// UNIT=2 keeps the default field reachable within the cycle budget.
module tb_video_timing_gen;

  localparam int XW   = 13;
  localparam int YW   = 9;
  localparam int UNIT = 2;

  typedef struct packed {
    int ht; int ha; int hs; int hsy;
    int vt; int va; int vs; int vsy;
    int il;
  } mcfg_t;

  localparam mcfg_t DEF = '{
    ht: 120, ha: 96, hs: 20, hsy: 9,
    vt: 312, va: 280, vs: 26, vsy: 3,
    il: 0
  };
  localparam mcfg_t TCFG = '{
    ht: 4, ha: 2, hs: 1, hsy: 1,
    vt: 10, va: 6, vs: 2, vsy: 1,
    il: 1
  };

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [YW-1:0] line_cmp;
  logic          irq_line;
  logic [XW-1:0] video_x;
  logic [YW-1:0] video_y;
  logic          hsync, vsync, hblank, vblank;
  logic          new_line, new_frame;
  logic          parity, fake_parity;

  mcfg_t offer = DEF;
  bit    offer_v = 1'b0;

  always #5 clk = ~clk;

  video_timing_gen_if #(.YW(YW)) cfg_if ();

  assign cfg_if.cfg_valid     = offer_v;
  assign cfg_if.cfg_h_total   = offer.ht[7:0];
  assign cfg_if.cfg_h_active  = offer.ha[7:0];
  assign cfg_if.cfg_h_start   = offer.hs[7:0];
  assign cfg_if.cfg_h_sync    = offer.hsy[7:0];
  assign cfg_if.cfg_v_total   = offer.vt[YW-1:0];
  assign cfg_if.cfg_v_active  = offer.va[YW-1:0];
  assign cfg_if.cfg_v_start   = offer.vs[YW-1:0];
  assign cfg_if.cfg_v_sync    = offer.vsy[YW-1:0];
  assign cfg_if.cfg_interlace = offer.il[0];

  video_timing_gen #(
    .XW(XW), .YW(YW), .UNIT(UNIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg(cfg_if),
    .line_cmp(line_cmp),
    .irq_line(irq_line),
    .video_x(video_x),
    .video_y(video_y),
    .hsync(hsync),
    .vsync(vsync),
    .hblank(hblank),
    .vblank(vblank),
    .new_line(new_line),
    .new_frame(new_frame),
    .parity(parity),
    .fake_parity(fake_parity)
  );

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int nl_last = 0, nl_per = 0;
  int nf_last = 0, nf_per = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      if (errs <= 30)
        $display("FAIL %s cyc=%0d got=%0d exp=%0d",
                 tag, cyc, got, exp);
    end
  endtask

  // Model: raster position plus active/pending timing sets.
  mcfg_t ma, mp;
  bit    mpv;
  int    mx, my;
  bit    mpar, mfpar, mhb, mvb;
  bit    mnl, mnf, mirq, merr;
  bit    m_wrapped, m_fended;

  function automatic bit is_legal(mcfg_t c);
    return c.ht >= 2 && c.hsy < c.ht &&
           c.hs + c.ha <= c.ht &&
           c.vsy < c.vt && c.vs + c.va <= c.vt;
  endfunction

  function automatic bit fend_next();
    int xt, flen;
    xt   = ma.ht * UNIT;
    flen = ma.vt + (mpar ? 0 : 1);
    return mx == xt - 1 && my == flen - 1;
  endfunction

  function automatic bit exp_hsync();
    return m_wrapped && mx < ma.hsy * UNIT;
  endfunction

  // Sync windows as spans of the linear position y*line+x.
  function automatic bit exp_vsync();
    int xt, p;
    xt = ma.ht * UNIT;
    p  = my * xt + mx;
    if (mpar)
      return m_fended && p < ma.vsy * xt;
    return p >= xt / 2 && p < ma.vsy * xt + xt / 2;
  endfunction

  task automatic model_step();
    int xt, flen, vsp;
    bit wrap, fend, xfer;
    if (reset) begin
      ma = DEF; mpv = 0; mx = 0; my = 0;
      mpar = 1; mfpar = 1; mhb = 1; mvb = 1;
      mnl = 0; mnf = 0; mirq = 0; merr = 0;
      m_wrapped = 0; m_fended = 0;
      return;
    end
    xt   = ma.ht * UNIT;
    flen = ma.vt + (mpar ? 0 : 1);
    vsp  = ma.vs + (mpar ? 0 : 1);
    wrap = (mx == xt - 1);
    fend = wrap && (my == flen - 1);
    xfer = offer_v && !mpv;
    mhb  = !(mx >= ma.hs * UNIT &&
             mx < (ma.hs + ma.ha) * UNIT);
    mvb  = !(my >= vsp && my < vsp + ma.va);
    merr = xfer && !is_legal(offer);
    mnl  = wrap;
    mnf  = fend;
    if (fend) begin
      mpar  = mpar ? !ma.il[0] : 1'b1;
      mfpar = !mfpar;
      m_fended = 1;
      if (mpv) begin
        ma  = mp;
        mpv = 0;
      end
    end
    if (xfer && is_legal(offer)) begin
      mp  = offer;
      mpv = 1;
    end
    mx = wrap ? 0 : mx + 1;
    my = fend ? 0 : (wrap ? my + 1 : my);
    if (wrap)
      m_wrapped = 1;
`ifdef VT_LINE_IRQ_EN
    mirq = wrap && (my == int'(line_cmp));
`else
    mirq = 0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    chk("video_x", video_x, mx);
    chk("video_y", video_y, my);
    chk("parity", parity, mpar);
    chk("fake_parity", fake_parity, mfpar);
    chk("hsync", hsync, exp_hsync());
    chk("vsync", vsync, exp_vsync());
    chk("hblank", hblank, mhb);
    chk("vblank", vblank, mvb);
    chk("new_line", new_line, mnl);
    chk("new_frame", new_frame, mnf);
    chk("irq_line", irq_line, mirq);
    chk("cfg_ready", cfg_if.cfg_ready, !mpv);
    chk("cfg_err", cfg_if.cfg_err, merr);
    if (new_line) begin
      nl_per  = cyc - nl_last;
      nl_last = cyc;
    end
    if (new_frame) begin
      nf_per  = cyc - nf_last;
      nf_last = cyc;
    end
  endtask

  task automatic wait_pulse(input bit frame, input int limit);
    for (int i = 0; i < limit; i++) begin
      tick();
      if (frame ? new_frame : new_line)
        return;
    end
    chk(frame ? "frame_timeout" : "line_timeout", 0, 1);
  endtask

  function automatic mcfg_t rand_cfg();
    mcfg_t c;
    c.ht  = $urandom_range(2, 8);
    c.ha  = $urandom_range(0, c.ht);
    c.hs  = $urandom_range(0, c.ht - c.ha);
    c.hsy = $urandom_range(1, c.ht - 1);
    c.vt  = $urandom_range(2, 14);
    c.va  = $urandom_range(0, c.vt);
    c.vs  = $urandom_range(0, c.vt - c.va);
    c.vsy = $urandom_range(1, c.vt - 1);
    c.il  = $urandom_range(0, 1);
    if ($urandom_range(0, 3) == 0) begin
      case ($urandom_range(0, 2))
        0: c.hs = c.ht - c.ha + 1;
        1: c.vsy = c.vt;
        default: c.ht = 1;
      endcase
    end
    return c;
  endfunction

  initial begin
    int hs_cnt, hb_cnt;
    line_cmp = YW'(5);
    repeat (3) tick();
    reset = 1'b0;

    // Default timing: line period, hsync and hblank widths.
    wait_pulse(1'b0, 400);
    hs_cnt = 0;
    hb_cnt = 0;
    for (int i = 0; i < 120 * UNIT; i++) begin
      hs_cnt += int'(hsync);
      hb_cnt += int'(!hblank);
      tick();
    end
    chk("line_period", nl_per, 120 * UNIT);
    chk("hsync_width", hs_cnt, 9 * UNIT);
    chk("hblank_low", hb_cnt, 96 * UNIT);

    // Illegal horizontal window is rejected.
    offer   = DEF;
    offer.hs = 100;
    offer.ha = 30;
    offer_v = 1'b1;
    tick();
    offer_v = 1'b0;
    chk("err_pulse", cfg_if.cfg_err, 1);
    chk("err_ready", cfg_if.cfg_ready, 1);
    tick();
    chk("err_clear", cfg_if.cfg_err, 0);

    // Test timing goes pending; a second offer stalls.
    offer   = TCFG;
    offer_v = 1'b1;
    tick();
    chk("p_full", cfg_if.cfg_ready, 0);
    wait_pulse(1'b1, 80000);
    chk("ready_at_fend", cfg_if.cfg_ready, 1);
    tick();
    offer_v = 1'b0;
    chk("second_xfer", cfg_if.cfg_ready, 0);
    wait_pulse(1'b1, 400);
    chk("odd_field_len", nf_per, 10 * 4 * UNIT);
    chk("even_parity", parity, 0);
    wait_pulse(1'b1, 400);
    chk("even_field_len", nf_per, 11 * 4 * UNIT);
    chk("odd_parity", parity, 1);

    // Transfer coinciding with a field-end edge stays pending.
    for (int i = 0; i < 400; i++) begin
      if (fend_next() && !mpv)
        break;
      tick();
    end
    chk("fend_found", fend_next() && !mpv, 1);
    offer   = rand_cfg();
    offer.ht = 6;
    offer.hs = 0;
    offer.ha = 6;
    offer.hsy = 2;
    offer_v = 1'b1;
    tick();
    offer_v = 1'b0;
    chk("xfer_nf", new_frame, 1);
    chk("xfer_pending", cfg_if.cfg_ready, 0);

    // Random offers and line-compare values.
    for (int i = 0; i < 6000; i++) begin
      offer_v = ($urandom_range(0, 5) == 0);
      if (offer_v)
        offer = rand_cfg();
      if ($urandom_range(0, 99) == 0)
        line_cmp = ($urandom_range(0, 1) == 1)
                   ? YW'(400)
                   : YW'($urandom_range(0, 15));
      tick();
    end
    offer_v = 1'b0;

    // Reset mid-field restores everything.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_x", video_x, 0);
    chk("rst_ready", cfg_if.cfg_ready, 1);
    repeat (300) tick();

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Runtime-programmable raster timing generator for the MCD212 video path. It generalises the fixed-table video timing block: pixel-clock units per timing cycle and counter widths are parameters, and all horizontal and vertical timing values are loaded at run time through a valid/ready config port. New config is shadowed and applied only at a field boundary. The block sits between the clock/reset domain and the pixel fetch/display pipeline, and drives counters, sync, blanking and field parity.

## Interface
- XW, 13: width of video_x.
- YW, 9: width of video_y and all vertical config fields.
- UNIT, 16: clocks per timing unit. All horizontal config values are in units. 255*UNIT must be ≤ 2^XW−1.

- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- cfg_valid  in  1  config offer.
- cfg_ready  out  1  config accept. High when no config is pending.
- cfg_h_total, cfg_h_active, cfg_h_start, cfg_h_sync  in  8 each  horizontal timing, in units.
- cfg_v_total, cfg_v_active, cfg_v_start, cfg_v_sync  in  YW each  vertical timing, in lines. cfg_v_total is the odd-field length.
- cfg_interlace  in  1  1 = interlaced scan.
- cfg_err  out  1  one-cycle pulse when an illegal config is rejected.
- line_cmp  in  YW  line-compare value.
- irq_line  out  1  line-compare pulse.
- video_x  out  XW;  video_y  out  YW.
- hsync, vsync, hblank, vblank  out  1 each.
- new_line, new_frame  out  1 each  one-cycle pulses.
- parity  out  1  1 = odd field. Always 1 when non-interlaced.
- fake_parity  out  1  toggles every field.

## Operation
- Active config (A) and pending config (P).
  - Reset loads A with HT=120, HA=96, HS=20, HSY=9, VT=312, VA=280, VS=26, VSY=3, interlace=0.
  - Reset clears P.
- Handshake: a transfer occurs when cfg_valid && cfg_ready.
  - The offered config is checked on acceptance.
  - It is legal when all of these hold: HT≥2; HSY<HT; HS+HA≤HT; VSY<VT; VS+VA≤VT.
  - Legal: written to P; cfg_ready drops the next cycle.
  - Illegal: discarded; cfg_err pulses the next cycle; A and P are unchanged.
- Counters:
  - x runs 0..HT*UNIT−1.
  - At the last x, x wraps to 0 and y advances.
  - Odd field (parity=1): lines 0..VT−1.
  - Even field (parity=0): lines 0..VT, which adds the half-line.
- Field end (last x of the last line):
  - y goes to 0, fake_parity toggles, and new_frame pulses.
  - Odd→even happens only if A.interlace; otherwise parity stays 1.
  - Even→odd always happens.
  - If P is valid, P is copied into A at this edge, P clears and cfg_ready rises.
- Switching interlace off during an even field takes effect at that field's end, which goes to odd.
- hsync: set at x wrap; cleared when x==HSY*UNIT.
- vsync:
  - Odd field: set at field start; cleared at x==0 on y==VSY.
  - Even field: set at x==HT*UNIT/2 on y==0; cleared at x==HT*UNIT/2 on y==VSY.
- Blanking:
  - hblank = !(HS*UNIT ≤ x < (HS+HA)*UNIT).
  - vblank = !(VS' ≤ y < VS'+VA), where VS' = VS+1 in even fields, else VS.
- All products are computed at XW bits and all sums at YW+1 bits, with no wrap.

## Timing
- Reset values: video_x=0, video_y=0, parity=1, fake_parity=1, hsync=0, vsync=0, hblank=1, vblank=1, new_line=0, new_frame=0, irq_line=0, cfg_err=0, cfg_ready=1.
- new_line pulses on the cycle when x==0 after a wrap. It does not pulse on the first cycle after reset.
- hblank and vblank are registered: 1-cycle latency relative to video_x/video_y.
- sync outputs, new_line and new_frame are aligned with the counters.
- A cfg transfer on the same cycle as a field-end edge lands in P. It applies at the following field end, not the current one.
- Reset mid-field: counters, A, P and all outputs return to their reset values on the next edge.

## Configuration
- VT_LINE_IRQ_EN defined: irq_line pulses for one cycle together with new_line when the new y equals line_cmp. It never pulses when line_cmp ≥ the current field length.
- Not defined: irq_line is tied to 0 and line_cmp is ignored. The ports remain present.

## Test plan
- Reset, then hold for 2 lines → line period 1920 clocks; hsync high for 144 clocks; hblank low for x in 320..1855 (1-cycle lag); parity=1.
- Non-interlaced default → new_frame every 312*1920 clocks; fake_parity alternates; vsync high for 3 lines.
- Config HT=4, HA=2, HS=1, HSY=1, VT=10, VA=6, VS=2, VSY=1, interlace=1 → applied at the next field end; then odd field 10 lines, even field 11 lines, even vsync edges at x=32, even-field vblank low for y 3..8.
- Offer a second config while P is full → cfg_ready=0 and no transfer; transfer completes the cycle after the field end.
- Offer HS=100, HA=30, HT=120 → cfg_err pulse; A unchanged; cfg_ready stays 1.
- With VT_LINE_IRQ_EN and line_cmp=5 → irq_line pulses once per field at y=5, x=0; with line_cmp=400 → no pulse.
